// File: rtl/sdp_relu_seq.sv
// Layer-level sequencer for the SDP ReLU datapath: counts beats, applies per-lane ReLU or bypass.
// Optional macro SDP_RELU_CLIP_EN adds cfg_clip_max and ReLU-N clipping of non-negative lanes.
module sdp_relu_seq #(
  parameter int NUM_LANES  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rst,
  input  logic                            op_en,
  input  logic                            cfg_bypass,
  input  logic [CNT_WIDTH-1:0]            cfg_beat_cnt,
`ifdef SDP_RELU_CLIP_EN
  input  logic [DATA_WIDTH-1:0]           cfg_clip_max,
`endif
  input  logic                            in_pvld,
  output logic                            in_prdy,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_pd,
  output logic                            out_pvld,
  input  logic                            out_prdy,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_pd,
  output logic                            out_last,
  output logic                            op_busy,
  output logic                            op_done
);

  localparam int PD_WIDTH = NUM_LANES * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  bypass_q;
`ifdef SDP_RELU_CLIP_EN
  logic [DATA_WIDTH-1:0] clip_q;
`endif

  logic                  start_op;
  logic                  start_empty;
  logic                  in_acc;
  logic                  last_acc;
  logic                  drain_done;
  logic [PD_WIDTH-1:0]   relu_pd;
  logic [DATA_WIDTH-1:0] lane_v;
  logic [DATA_WIDTH-1:0] res_v;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Upstream is only ready in RUN when the output slot is free or draining this cycle.
  always_comb begin
    state_nxt   = state;
    in_prdy     = 1'b0;
    start_op    = 1'b0;
    start_empty = 1'b0;
    in_acc      = 1'b0;
    last_acc    = 1'b0;
    drain_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_en) begin
          if (cfg_beat_cnt == '0) begin
            start_empty = 1'b1;
          end else begin
            start_op  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        in_prdy = !out_pvld || out_prdy;
        in_acc  = in_pvld && (!out_pvld || out_prdy);
        if (in_acc && (beat_cnt == '0)) begin
          last_acc  = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_pvld && out_prdy && out_last) begin
          drain_done = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    relu_pd = '0;
    lane_v  = '0;
    res_v   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_v = in_pd[i*DATA_WIDTH +: DATA_WIDTH];
      if (bypass_q) begin
        res_v = lane_v;
      end else if (lane_v[DATA_WIDTH-1]) begin
        res_v = '0;
`ifdef SDP_RELU_CLIP_EN
      end else if (lane_v > clip_q) begin
        res_v = clip_q;
`endif
      end else begin
        res_v = lane_v;
      end
      relu_pd[i*DATA_WIDTH +: DATA_WIDTH] = res_v;
    end
  end

  // Counter holds beats remaining after the next accept; zero marks the final beat.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      beat_cnt <= '0;
      bypass_q <= 1'b0;
`ifdef SDP_RELU_CLIP_EN
      clip_q   <= '0;
`endif
      out_pvld <= 1'b0;
      out_last <= 1'b0;
      out_pd   <= '0;
      op_done  <= 1'b0;
    end else begin
      op_done <= start_empty || drain_done;
      if (start_op) begin
        beat_cnt <= cfg_beat_cnt - CNT_ONE;
        bypass_q <= cfg_bypass;
`ifdef SDP_RELU_CLIP_EN
        clip_q   <= cfg_clip_max;
`endif
      end else if (in_acc && (beat_cnt != '0)) begin
        beat_cnt <= beat_cnt - CNT_ONE;
      end
      if (in_acc) begin
        out_pvld <= 1'b1;
        out_pd   <= relu_pd;
        out_last <= last_acc;
      end else if (out_pvld && out_prdy) begin
        out_pvld <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

  assign op_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sdp_relu_seq.sv
// Randomized self-checking bench for sdp_relu_seq against a lane-level ReLU/ReLU-N reference model.
// Exercises the SDP_RELU_CLIP_EN scenario only when that macro is defined.
module tb_sdp_relu_seq;

  localparam int NL = 8;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int PD = NL * DW;

  logic          clk;
  logic          rst;
  logic          op_en;
  logic          cfg_bypass;
  logic [CW-1:0] cfg_beat_cnt;
  logic [DW-1:0] clip_max;
  logic          in_pvld;
  logic          in_prdy;
  logic [PD-1:0] in_pd;
  logic          out_pvld;
  logic          out_prdy;
  logic [PD-1:0] out_pd;
  logic          out_last;
  logic          op_busy;
  logic          op_done;

  int vectors;
  int miscompares;
  logic [PD-1:0] exp_q[$];

  sdp_relu_seq #(.NUM_LANES(NL), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .op_en          (op_en),
    .cfg_bypass     (cfg_bypass),
    .cfg_beat_cnt   (cfg_beat_cnt),
`ifdef SDP_RELU_CLIP_EN
    .cfg_clip_max   (clip_max),
`endif
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_pd          (in_pd),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_pd         (out_pd),
    .out_last       (out_last),
    .op_busy        (op_busy),
    .op_done        (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a lane is a signed number; negatives become zero, positives optionally saturate.
  function automatic logic [DW-1:0] model_lane(input logic [DW-1:0] x, input bit byp);
    if (byp) return x;
    if ($signed(x) < 0) return '0;
`ifdef SDP_RELU_CLIP_EN
    if (x > clip_max) return clip_max;
`endif
    return x;
  endfunction

  function automatic logic [PD-1:0] model_beat(input logic [PD-1:0] pd, input bit byp);
    logic [PD-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) r[l*DW +: DW] = model_lane(pd[l*DW +: DW], byp);
    return r;
  endfunction

  function automatic logic [PD-1:0] gen_beat(input int mode, input int beat);
    logic [DW-1:0] corners [8];
    logic [DW-1:0] clipv [3];
    logic [PD-1:0] pd;
    corners = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF,
                32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0080};
    clipv   = '{32'd3, 32'd7, 32'hFFFF_FFFF};
    pd = '0;
    for (int l = 0; l < NL; l++) begin
      case (mode)
        1:       pd[l*DW +: DW] = (l % 2 == 0) ? 32'h0000_0005 : 32'hFFFF_FFFB;
        2:       pd[l*DW +: DW] = corners[(l + beat) % 8];
        3:       pd[l*DW +: DW] = clipv[(l + beat) % 3];
        default: pd[l*DW +: DW] = $urandom();
      endcase
    end
    return pd;
  endfunction

  // Starts one operation of n beats and streams it through, scoring every cycle.
  task automatic run_stream(input int n, input bit byp, input int mode, input int stall_beat,
                            input int stall_len, input bit rand_valid, input bit rand_ready,
                            input bit poke_en);
    int sent, recv, stalled, budget;
    bit acc, drn, exp_rdy;
    logic [PD-1:0] cur_pd;
    exp_q.delete();
    sent = 0; recv = 0; stalled = 0;
    budget = n * 4 + 100;
    cfg_beat_cnt = CW'(n);
    cfg_bypass = byp;
    op_en = 1'b1; in_pvld = 1'b0; out_prdy = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    vectors++;
    if (op_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_after_start: got %b expected 1", op_busy);
    end
    cur_pd = gen_beat(mode, 0);
    for (int cyc = 0; cyc < budget && recv < n; cyc++) begin
      in_pvld = (sent < n) && (!rand_valid || $urandom_range(0, 3) != 0);
      in_pd = cur_pd;
      if (stall_beat > 0 && out_pvld && recv == stall_beat - 1 && stalled < stall_len) begin
        out_prdy = 1'b0;
        stalled++;
      end else begin
        out_prdy = !rand_ready || $urandom_range(0, 2) != 0;
      end
      op_en = poke_en && (cyc == 1);
      if (op_en) begin
        cfg_beat_cnt = 16'd2;
        cfg_bypass = !byp;
      end
      #1;
      acc = in_pvld && in_prdy;
      drn = out_pvld && out_prdy;
      exp_rdy = (sent < n) && (!out_pvld || out_prdy);
      vectors++;
      if (in_prdy !== exp_rdy) begin
        miscompares++;
        $display("[TB] FAIL in_prdy: got %b expected %b (beat %0d)", in_prdy, exp_rdy, sent);
      end
      vectors++;
      if (out_pvld !== (exp_q.size() > 0)) begin
        miscompares++;
        $display("[TB] FAIL out_pvld: got %b expected %b (beat %0d)", out_pvld, exp_q.size() > 0, recv);
      end
      if (out_pvld === 1'b1 && exp_q.size() > 0) begin
        vectors++;
        if (out_pd !== exp_q[0]) begin
          miscompares++;
          $display("[TB] FAIL out_pd beat %0d: got %h expected %h", recv, out_pd, exp_q[0]);
        end
        vectors++;
        if (out_last !== (recv == n - 1)) begin
          miscompares++;
          $display("[TB] FAIL out_last beat %0d: got %b expected %b", recv, out_last, recv == n - 1);
        end
      end
      vectors++;
      if (op_busy !== 1'b1 || op_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL busy_done_mid_op: got busy=%b done=%b expected busy=1 done=0", op_busy, op_done);
      end
      @(posedge clk); #1;
      if (drn) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        recv++;
      end
      if (acc) begin
        exp_q.push_back(model_beat(cur_pd, byp));
        sent++;
        cur_pd = gen_beat(mode, sent);
      end
    end
    op_en = 1'b0; in_pvld = 1'b0; out_prdy = 1'b1;
    vectors++;
    if (recv < n) begin
      miscompares++;
      $display("[TB] FAIL stream_timeout: got %0d beats expected %0d", recv, n);
    end else begin
      vectors++;
      if (op_done !== 1'b1 || op_busy !== 1'b0 || out_pvld !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL completion: got done=%b busy=%b pvld=%b expected 1/0/0", op_done, op_busy, out_pvld);
      end
      @(posedge clk); #1;
      vectors++;
      if (op_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL done_pulse_width: got %b expected 0", op_done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({in_prdy, out_pvld, out_last, op_busy, op_done} !== 5'b0 || out_pd !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got rdy=%b pvld=%b last=%b busy=%b done=%b pd=%h expected all 0",
               in_prdy, out_pvld, out_last, op_busy, op_done, out_pd);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_relu_basic();
    run_stream(3, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    run_stream(3, 1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_stream(8, 1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    run_stream(8, 1'b0, 2, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream(4, 1'b0, 0, 2, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_len();
    cfg_beat_cnt = '0;
    op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    vectors++;
    if (op_done !== 1'b1 || op_busy !== 1'b0 || in_prdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_len_done: got done=%b busy=%b rdy=%b expected 1/0/0", op_done, op_busy, in_prdy);
    end
    @(posedge clk); #1;
    vectors++;
    if (op_done !== 1'b0 || op_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_len_after: got done=%b busy=%b expected 0/0", op_done, op_busy);
    end
  endtask

  task automatic test_op_en_in_run();
    run_stream(5, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    run_stream(6, 1'b1, 2, 0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_stream($urandom_range(1, 12), 1'($urandom_range(0, 1)), 0, 0, 0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_max_count();
    run_stream(65535, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_drain();
    bit seen;
    cfg_beat_cnt = 16'd1; cfg_bypass = 1'b0;
    out_prdy = 1'b0; in_pvld = 1'b0;
    op_en = 1'b1;
    @(posedge clk); #1;
    op_en = 1'b0;
    in_pvld = 1'b1;
    in_pd = gen_beat(0, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = (out_pvld === 1'b1);
    end
    in_pvld = 1'b0;
    vectors++;
    if (!seen || out_last !== 1'b1 || op_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL drain_entry: got pvld=%b last=%b busy=%b expected 1/1/1", out_pvld, out_last, op_busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({in_prdy, out_pvld, out_last, op_busy, op_done} !== 5'b0 || out_pd !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_in_drain: got rdy=%b pvld=%b last=%b busy=%b done=%b pd=%h expected all 0",
               in_prdy, out_pvld, out_last, op_busy, op_done, out_pd);
    end
    out_prdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (op_done !== 1'b0 || op_busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL no_done_after_reset: got done=%b busy=%b expected 0/0", op_done, op_busy);
      end
    end
    run_stream(1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef SDP_RELU_CLIP_EN
  task automatic test_clip();
    clip_max = 32'd6;
    run_stream(3, 1'b0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    run_stream(3, 1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    run_stream(6, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    clip_max = '1;
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; op_en = 1'b0; cfg_bypass = 1'b0; cfg_beat_cnt = '0;
    clip_max = '1; in_pvld = 1'b0; in_pd = '0; out_prdy = 1'b0;
    test_reset();
    test_relu_basic();
    test_bypass();
    test_backpressure();
    test_zero_len();
    test_op_en_in_run();
    test_random();
    test_reset_in_drain();
`ifdef SDP_RELU_CLIP_EN
    test_clip();
`endif
    test_max_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
